// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the parametrised single-port RAM.
//   state_t      : clear-sequencer state (CLEAR sweeps zeros, RUN serves accesses)
//   RDW_HOLD     : read-during-write policy, out keeps its value on a write
//   RDW_THROUGH  : read-during-write policy, out takes the write data
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int RDW_HOLD    = 0;
   localparam int RDW_THROUGH = 1;

endpackage : ram_pkg

// File: rtl/ram_param.sv
// ram_param -- parametrised single-port synchronous RAM with a hardware
// clear sequencer and a registered read port.
//
// Parameters
//   DATA_WIDTH     word width in bits
//   ADDR_WIDTH     address width, DEPTH = 2**ADDR_WIDTH words
//   CLEAR_ON_RESET 1: zero the whole array after reset, 0: start in RUN
//   RDW_MODE       RDW_HOLD or RDW_THROUGH (behaviour of out on a write)
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   en         in   access strobe, only honoured while ready=1
//   load       in   1 = write, 0 = read
//   address    in   word address
//   in         in   write data
//   out        out  registered read data
//   out_valid  out  one-cycle strobe, out carries a new value
//   clear      in   request to re-zero the whole array
//   ready      out  accesses are accepted (state RUN)
module ram_param
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 15,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int RDW_MODE       = RDW_HOLD
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   input  logic                  clear,
   output logic                  ready
);

   localparam int     DEPTH     = 2 ** ADDR_WIDTH;
   localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] out_q;
   logic                  out_valid_q, out_valid_d;

   // Single write port, shared between the sweep counter and the user side.
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rd;
   logic                  thru;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we          = 1'b0;
      waddr       = address;
      wdata       = in;
      rd          = 1'b0;
      thru        = 1'b0;
      out_valid_d = 1'b0;

      case (state_q)
         CLEAR: begin
            // User inputs, including a further clear, are ignored here.
            we    = 1'b1;
            waddr = cnt_q;
            wdata = '0;
            if (cnt_q == '1) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1'b1);
            end
         end

         RUN: begin
            if (en) begin
               if (load) begin
                  we = 1'b1;
                  if (RDW_MODE == RDW_THROUGH) begin
                     thru        = 1'b1;
                     out_valid_d = 1'b1;
                  end
               end else begin
                  rd          = 1'b1;
                  out_valid_d = 1'b1;
               end
            end
            // An access accepted together with clear still completes.
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end

         default: state_d = RST_STATE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Array contents are never touched by reset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (rd) begin
            out_q <= mem[address];
         end else if (thru) begin
            out_q <= in;
         end
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   // Decoded from the state register alone so it carries no input paths.
   assign ready     = (state_q == RUN);

endmodule : ram_param

// File: tb/tb_ram_param.sv
// tb_ram_param -- drives three ram_param configurations with one shared
// stimulus stream and compares each against its own behavioural model:
//   dut 0: CLEAR_ON_RESET=1, RDW_MODE=hold
//   dut 1: CLEAR_ON_RESET=1, RDW_MODE=write-through
//   dut 2: CLEAR_ON_RESET=0, RDW_MODE=hold
module tb_ram_param;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int NDUT  = 3;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b1;
   logic          en      = 1'b0;
   logic          load    = 1'b0;
   logic          clear   = 1'b0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] din     = '0;

   logic [DW-1:0] out_w [NDUT];
   logic          vld_w [NDUT];
   logic          rdy_w [NDUT];

   always #5 clock = ~clock;

   ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .RDW_MODE(0)) dut_hold (
      .clock(clock), .reset_n(reset_n), .en(en), .load(load), .address(address),
      .in(din), .out(out_w[0]), .out_valid(vld_w[0]), .clear(clear), .ready(rdy_w[0]));

   ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .RDW_MODE(1)) dut_thru (
      .clock(clock), .reset_n(reset_n), .en(en), .load(load), .address(address),
      .in(din), .out(out_w[1]), .out_valid(vld_w[1]), .clear(clear), .ready(rdy_w[1]));

   ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0), .RDW_MODE(0)) dut_noclr (
      .clock(clock), .reset_n(reset_n), .en(en), .load(load), .address(address),
      .in(din), .out(out_w[2]), .out_valid(vld_w[2]), .clear(clear), .ready(rdy_w[2]));

   // Reference model: a busy-cycle count stands in for the sweep; the array
   // is zeroed at once when a sweep starts since no access can observe it
   // before the sweep has finished.
   bit            cor    [NDUT] = '{1'b1, 1'b1, 1'b0};
   bit            thru_m [NDUT] = '{1'b0, 1'b1, 1'b0};
   int            busy   [NDUT];
   logic [DW-1:0] mmem   [NDUT][DEPTH];
   bit            known  [NDUT][DEPTH];
   logic [DW-1:0] mout   [NDUT];
   bit            mvld   [NDUT];
   bit            oknown [NDUT];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic zero_mem(input int k);
      for (int i = 0; i < DEPTH; i++) begin
         mmem[k][i]  = '0;
         known[k][i] = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         if (cor[k]) begin
            busy[k] = DEPTH;
            zero_mem(k);
         end else begin
            // A sweep cut short leaves partially cleared contents.
            if (busy[k] > 0) begin
               for (int i = 0; i < DEPTH; i++) known[k][i] = 1'b0;
            end
            busy[k] = 0;
         end
         mout[k]   = '0;
         mvld[k]   = 1'b0;
         oknown[k] = 1'b1;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < NDUT; k++) begin
         mvld[k] = 1'b0;
         if (busy[k] > 0) begin
            busy[k]--;
         end else begin
            if (en) begin
               if (load) begin
                  mmem[k][address]  = din;
                  known[k][address] = 1'b1;
                  if (thru_m[k]) begin
                     mout[k]   = din;
                     oknown[k] = 1'b1;
                     mvld[k]   = 1'b1;
                  end
               end else begin
                  mout[k]   = mmem[k][address];
                  oknown[k] = known[k][address];
                  mvld[k]   = 1'b1;
               end
            end
            if (clear) begin
               busy[k] = DEPTH;
               zero_mem(k);
            end
         end
      end
   endtask

   task automatic check_all(input string ph);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s dut%0d ready", ph, k), 32'(rdy_w[k]), 32'(busy[k] == 0));
         chk($sformatf("%s dut%0d out_valid", ph, k), 32'(vld_w[k]), 32'(mvld[k]));
         if (oknown[k]) begin
            chk($sformatf("%s dut%0d out", ph, k), 32'(out_w[k]), 32'(mout[k]));
         end
      end
   endtask

   task automatic tick(input string ph);
      @(posedge clock);
      model_step();
      #1;
      check_all(ph);
   endtask

   task automatic op(input bit e, input bit l, input int a, input logic [DW-1:0] d,
                     input bit c, input string ph);
      en      = e;
      load    = l;
      address = AW'(a);
      din     = d;
      clear   = c;
      tick(ph);
   endtask

   task automatic do_reset(input string ph);
      en      = 1'b0;
      load    = 1'b0;
      clear   = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all({ph, " in-reset"});
      repeat (2) @(posedge clock);
      #1;
      check_all({ph, " held"});
      reset_n = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         busy[k]   = 0;
         mout[k]   = '0;
         mvld[k]   = 1'b0;
         oknown[k] = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mmem[k][i]  = '0;
            known[k][i] = 1'b0;
         end
      end

      #2;
      do_reset("por");

      // Power-up sweep with stray read strobes that the clearing parts ignore.
      op(1'b0, 1'b0, 0, '0, 1'b0, "sweep first");
      chk("noclr ready first cycle", 32'(rdy_w[2]), 32'd1);
      chk("hold ready first cycle", 32'(rdy_w[0]), 32'd0);
      for (int i = 1; i < DEPTH; i++)
         op(1'($urandom), 1'b0, int'($urandom_range(0, DEPTH - 1)), '0, 1'b0, "sweep");
      chk("hold ready after sweep", 32'(rdy_w[0]), 32'd1);

      for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, a, '0, 1'b0, "read zero");
      op(1'b0, 1'b0, 0, '0, 1'b0, "idle");

      op(1'b1, 1'b1, 5, 16'hBEEF, 1'b0, "wr5");
      op(1'b1, 1'b0, 5, '0, 1'b0, "rd5");
      chk("rd5 out", 32'(out_w[0]), 32'h0000BEEF);
      op(1'b1, 1'b1, 7, 16'h1234, 1'b0, "rdw7");
      chk("rdw hold out", 32'(out_w[0]), 32'h0000BEEF);
      chk("rdw hold valid", 32'(vld_w[0]), 32'd0);
      chk("rdw thru out", 32'(out_w[1]), 32'h00001234);
      chk("rdw thru valid", 32'(vld_w[1]), 32'd1);
      op(1'b0, 1'b0, 0, '0, 1'b0, "idle");

      op(1'b1, 1'b1, 15, 16'h00C3, 1'b0, "wr15");
      op(1'b1, 1'b0, 15, '0, 1'b0, "rd15");
      chk("noclr rd15 out", 32'(out_w[2]), 32'h000000C3);

      for (int i = 0; i < 300; i++)
         op(($urandom % 4) != 0, 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
            DW'($urandom), ($urandom % 60) == 0, "random");
      repeat (DEPTH) op(1'b0, 1'b0, 0, '0, 1'b0, "drain");

      // Fill, then clear together with an accepted write.
      for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b1, a, 16'hFFFF, 1'b0, "fill");
      op(1'b1, 1'b1, 3, 16'hAAAA, 1'b1, "clear+wr");
      for (int i = 0; i < DEPTH; i++) begin
         op(1'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
            DW'($urandom), 1'($urandom), "clearing");
         if (i < DEPTH - 1) chk("ready low in sweep", 32'(rdy_w[0]), 32'd0);
      end
      chk("ready back after sweep", 32'(rdy_w[0]), 32'd1);
      for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, a, '0, 1'b0, "read cleared");
      chk("cleared addr15", 32'(out_w[2]), 32'd0);

      // Reset in the middle of a sweep restarts it from scratch.
      op(1'b1, 1'b1, 9, 16'h5A5A, 1'b0, "wr9");
      op(1'b0, 1'b0, 0, '0, 1'b1, "clear2");
      repeat (8) op(1'b0, 1'b0, 0, '0, 1'b0, "sweep2");
      do_reset("midsweep");
      for (int i = 0; i < DEPTH; i++) begin
         op(1'b1, 1'b0, int'($urandom_range(0, DEPTH - 1)), '0, 1'b0, "resweep");
         if (i < DEPTH - 1) chk("ready low after restart", 32'(rdy_w[1]), 32'd0);
      end
      for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, a, '0, 1'b0, "read after restart");
      op(1'b0, 1'b0, 0, '0, 1'b0, "idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ram_param

// File: doc/ram_param.md
# ram_param

Parametrised single-port synchronous RAM, the successor to the fixed 32K×16 data memory of the minicpuset. It adds width and depth parameters, an explicit access enable, a read-valid strobe and a selectable read-during-write policy. A hardware clear sequencer zeroes the array after reset or on request, which replaces simulation-only initialisation. It sits between the CPU datapath and its data/instruction address space.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 15, address width; DEPTH = 2**ADDR_WIDTH words
- CLEAR_ON_RESET, 1, 1 = run a clear sweep after reset; 0 = array contents undefined after power-up and left untouched by reset
- RDW_MODE, 0, read-during-write policy: 0 = out holds its value on a write; 1 = write-through (out takes `in`)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  access strobe; sampled only while ready=1
- load  input  1  1 = write, 0 = read (qualified by en)
- address  input  ADDR_WIDTH  word address
- in  input  DATA_WIDTH  write data
- out  output  DATA_WIDTH  registered read data
- out_valid  output  1  high for one cycle when out carries a new value
- clear  input  1  single-cycle request to re-zero the whole array
- ready  output  1  high when accesses are accepted (state RUN)

## Operation
- FSM states: CLEAR, RUN.
  - Reset state is CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - CLEAR→RUN after the word at DEPTH-1 is written.
  - RUN→CLEAR on clear=1.
- CLEAR: a sweep counter (ADDR_WIDTH bits) writes 0 to mem[counter] each cycle, starting at 0. Counter reset value is 0, and it is reloaded to 0 on entry to CLEAR.
  - en, load and clear are ignored in CLEAR.
  - out holds its value; out_valid stays 0.
- RUN, en=1, load=0: out <= mem[address], out_valid <= 1.
- RUN, en=1, load=1: mem[address] <= in.
  - RDW_MODE=0: out holds, out_valid <= 0.
  - RDW_MODE=1: out <= in, out_valid <= 1.
- RUN, en=0: no array access; out holds, out_valid <= 0.
- clear=1 together with en=1 in RUN: the access completes this cycle, then the FSM enters CLEAR.
- ready = (state == RUN), decoded from the state register only (glitch-free, no input paths).
- Address is used modulo DEPTH; there is no out-of-range behaviour.

## Timing
- Reset values: out=0, out_valid=0, ready=!CLEAR_ON_RESET, counter=0.
- Read latency is 1: a read sampled at edge N produces out and out_valid=1 after edge N, and out_valid falls after edge N+1 unless another read occurs.
- Back-to-back reads, one per cycle, are supported at full throughput.
- A write sampled at edge N is visible to a read sampled at edge N+1.
- The clear sweep lasts exactly DEPTH cycles. With clear sampled at edge N, ready falls after edge N, and ready rises after edge N+DEPTH.
- After reset release with CLEAR_ON_RESET=1, ready rises DEPTH cycles after the first edge.
- Reset asserted during a sweep: the FSM returns to its reset state and the counter returns to 0. The sweep restarts from 0 after release, and partially cleared contents are not relied upon.

## Structure
- The shared package `ram_pkg` holds:
  - the state enum (CLEAR, RUN)
  - RDW_MODE constants RDW_HOLD=0 and RDW_THROUGH=1
- The memory array is a single inferred synchronous array, with one write port muxed between the sweep counter and the user address.
- No sub-module is needed: the clear sequencer (FSM and counter) stays inline, at about 150 lines of RTL.

## Test plan
Bench configuration: DATA_WIDTH=16, ADDR_WIDTH=4 (DEPTH=16) unless stated.
- Reset with CLEAR_ON_RESET=1 → ready=0 for exactly 16 cycles, then 1; reading addresses 0..15 returns 16'h0000 each, with out_valid=1 one cycle after each request.
- Write 16'hBEEF to address 5, then read address 5 on the next cycle → out=16'hBEEF with out_valid=1, one cycle after the read.
- RDW_MODE=0: read address 5 (out=16'hBEEF), then write 16'h1234 to address 7 → out stays 16'hBEEF, out_valid=0. RDW_MODE=1, same stimulus → out=16'h1234, out_valid=1.
- Fill every address with 16'hFFFF, pulse clear while en=1 and load=1 to address 3 with 16'hAAAA → ready low for 16 cycles, en pulses during the sweep are ignored, and all addresses then read 16'h0000.
- Assert reset_n=0 at sweep cycle 8 and release → ready stays low 16 full cycles after release.
- CLEAR_ON_RESET=0 → ready=1 on the first cycle after reset release, and a write then read of address 15 with 16'h00C3 returns 16'h00C3.
